// File: rtl/led_frame_builder_if.sv
// Row-write and commit handshake between a frame producer and led_frame_builder.
interface led_frame_builder_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_pending;

    modport master (
        output wr_valid, wr_row, wr_data, commit,
        input  wr_ready, commit_pending
    );

    modport slave (
        input  wr_valid, wr_row, wr_data, commit,
        output wr_ready, commit_pending
    );
endinterface

// File: rtl/led_frame_builder.sv
// Double-buffered 8x8 LED frame store with a scan-clock generator; committed
// back-buffer contents are published mid-frame so d is stable around each load edge.
module led_frame_builder #(
    parameter int SCAN_DIV = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    led_frame_builder_if.slave   wr,
    output logic                 scanclk,
    output logic                 frame_tick,
    output logic [63:0]          d
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [2:0]    phase;
    logic [63:0]   back;
    logic          pending;
    logic          wrap;
    logic          rise;
    logic          swap;
    logic          wr_accept;

    assign wrap      = (div_cnt == DIV_LAST);
    assign rise      = wrap && !scanclk;
    // The swap point sits on the falling edge while phase==4, half a frame from the load edge.
    assign swap      = wrap && scanclk && (phase == 3'd4);
    assign wr_accept = wr.wr_valid && !pending;

    assign wr.wr_ready       = !pending;
    assign wr.commit_pending = pending;

    // NOTE: back is only 64 flops, so it is reset like any other register; a reset
    // must wipe half-built frames rather than leave stale rows to be committed later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            phase      <= 3'd0;
            scanclk    <= 1'b0;
            frame_tick <= 1'b0;
            back       <= 64'h0;
            d          <= 64'h0;
            pending    <= 1'b0;
        end else begin
            // NOTE: every state update uses <= so all registers see pre-edge values,
            // which is what lets a same-cycle write land before the commit is seen.
            div_cnt    <= wrap ? '0 : div_cnt + DW'(1);
            frame_tick <= rise && (phase == 3'd0);
            if (wrap) begin
                scanclk <= !scanclk;
            end
            if (rise) begin
                phase <= phase + 3'd1;
            end
            if (wr_accept) begin
                back[{~wr.wr_row, 3'b000} +: 8] <= wr.wr_data;
            end
            if (swap && pending) begin
                d       <= back;
                pending <= 1'b0;
            end else if (wr.commit) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: doc/led_frame_builder.md
LED_FRAME_BUILDER -- requirements
Module: led_frame_builder

Interface
REQ-001 The block SHALL have one parameter: SCAN_DIV, default 2048, clk cycles per scanclk half-period (legal range >= 2).
REQ-002 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wr_valid  input  1  row-write request into the back buffer.
REQ-005 wr_ready  output  1  block can accept a row write this cycle.
REQ-006 wr_row  input  3  row index 0..7 for the write.
REQ-007 wr_data  input  8  pixel byte for the row; bit 7 is the leftmost column.
REQ-008 commit  input  1  single-cycle request to publish the back buffer.
REQ-009 commit_pending  output  1  commit accepted, swap not yet done.
REQ-010 scanclk  output  1  row-scan clock for the downstream LED matrix driver.
REQ-011 frame_tick  output  1  one-cycle pulse marking the downstream frame-load edge.
REQ-012 d  output  64  front-buffer frame; row r occupies d[63-8r:56-8r].

Function
REQ-013 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0. On the wrap cycle it SHALL toggle scanclk, giving a period of 2*SCAN_DIV clk cycles.
REQ-014 A 3-bit phase counter SHALL increment, with mod-8 wrap, on every clk edge that drives scanclk 0->1.
REQ-015 frame_tick SHALL be 1 for exactly the cycle on which scanclk is driven 0->1 while phase==0 before the increment; otherwise 0.
REQ-016 The swap point SHALL be the clk edge that drives scanclk 1->0 while phase==4. This is mid-frame, so d is stable for 3+ scanclk periods around every load edge.
REQ-017 wr_ready SHALL equal !commit_pending.
REQ-018 When wr_valid && wr_ready, back[wr_row] SHALL take wr_data on that edge. When wr_valid && !wr_ready, the write SHALL be dropped and back left unchanged.
REQ-019 commit while commit_pending==0 SHALL set commit_pending on the next edge. commit while commit_pending==1 SHALL be ignored.
REQ-020 A write accepted in the same cycle as commit SHALL be included in the committed frame.
REQ-021 At the swap point with commit_pending==1, d SHALL load the full back buffer and commit_pending SHALL clear on the same edge.
REQ-022 A commit arriving on the swap-point cycle with commit_pending==0 SHALL wait for the next swap point, 8 scanclk periods later.
REQ-023 The back buffer SHALL retain its contents after a swap, so partial updates are incremental.
REQ-024 d SHALL change only at a swap point; scanclk, frame_tick and d SHALL be registered, with no combinational path from inputs.
REQ-025 Maximum commit-to-display latency SHALL be 16*SCAN_DIV + 1 clk cycles.

Reset
REQ-026 While rst is high, all of the following SHALL hold:
- div_cnt=0, phase=0, scanclk=0, frame_tick=0
- commit_pending=0, wr_ready=1
- back=0, d=64'h0
REQ-027 Asserting rst mid-frame or with a commit pending SHALL discard the pending commit and all back-buffer contents immediately.
REQ-028 After rst deasserts, scanclk SHALL first rise on the SCAN_DIV-th clk edge, and that edge SHALL carry frame_tick=1.

Verification (SCAN_DIV=4: scanclk period 8 clk, frame 64 clk)
REQ-029 Reset release -> scanclk rises on edge 4 with frame_tick=1; frame_tick then recurs every 64 clk; d=0 and wr_ready=1 throughout.
REQ-030 Write rows 0..7 = 01,02,04,08,10,20,40,80, then commit -> wr_ready low from the next cycle. At the first phase-4 falling edge, d=64'h0102040810204080 and commit_pending clears.
REQ-031 While pending, a write of row 3 = FF and a second commit are issued -> both are ignored; d is unchanged after the swap and back[3] still 08.
REQ-032 Write row 7 = AA in the same cycle as commit -> after the swap d[7:0]=AA and other rows hold prior values.
REQ-033 commit issued exactly on the swap-point cycle -> no swap there; the swap occurs 64 clk later.
REQ-034 rst pulsed while commit_pending=1 -> d=0, commit_pending=0 and scanclk=0 immediately (asynchronous), and the REQ-029 timing restarts.
